// File: rtl/screen_reset_pkg.sv
// Shared types and defaults for the screen-reset request logic.
// Contents:
//   sr_state_t   - request FSM state encoding
//   DEF_*        - default parameter values for a 50 MHz system clock
//   max_int      - elaboration-time helper for sizing counters
package screen_reset_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } sr_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
  localparam int DEF_HOLD_FRAMES     = 2;
  localparam int DEF_COOLDOWN_FRAMES = 30;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// single-cycle press pulse on the debounced 1->0 transition.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   key_n       - raw active-low button, asynchronous and bouncing
//   press       - one-cycle pulse, the cycle after the debounced level falls
module key_debounce
  import screen_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] db_cnt_q;
  logic [CNT_W-1:0] db_cnt_d;
  logic             press_q;
  logic             press_d;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    // Any sample that agrees with the accepted level restarts the count, so
    // only an uninterrupted run of the new level is accepted.
    if (sync2_q != stable_q) begin
      if (db_cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
    // Falling edge of the accepted level only; release produces nothing.
    press_d = stable_dly_q & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      db_cnt_q     <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= key_n;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      db_cnt_q     <= db_cnt_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/screen_reset_request.sv
// Screen-reset request generator feeding the CPU's screen_reset PIO input.
// A debounced button press or a round_over pulse opens a request; the
// request is aligned to the next VGA frame start, held for HOLD_FRAMES
// frames, then followed by COOLDOWN_FRAMES frames during which new
// requests are dropped.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   key_n         - raw active-low button (asynchronous)
//   round_over    - single-cycle pulse from game logic (synchronous)
//   vsync_n       - VGA vertical sync, active-low (asynchronous)
//   screen_reset  - high while the request is being presented (ACTIVE)
//   busy          - high whenever a request is in progress or cooling down
module screen_reset_request
  import screen_reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_FRAMES     = DEF_HOLD_FRAMES,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic round_over,
  input  logic vsync_n,
  output logic screen_reset,
  output logic busy
);

  localparam int                FCNT_MAX  = max_int(HOLD_FRAMES, COOLDOWN_FRAMES);
  localparam int                FCNT_W    = $clog2(FCNT_MAX + 1);
  localparam logic [FCNT_W-1:0] HOLD_LAST = FCNT_W'(HOLD_FRAMES);
  localparam logic [FCNT_W-1:0] COOL_LAST = FCNT_W'(COOLDOWN_FRAMES);

  logic              press;
  logic              req;
  logic              vs_sync1_q;
  logic              vs_sync2_q;
  logic              vs_prev_q;
  logic              frame_edge_q;
  logic              frame_edge_d;
  sr_state_t         state_q;
  sr_state_t         state_d;
  logic [FCNT_W-1:0] fcnt_q;
  logic [FCNT_W-1:0] fcnt_d;
  logic [FCNT_W-1:0] fcnt_inc;
  logic              screen_reset_q;
  logic              screen_reset_d;
  logic              busy_q;
  logic              busy_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk  (clk),
    .reset(reset),
    .key_n(key_n),
    .press(press)
  );

  assign req = press | round_over;

  // Frame start is the synchronized vsync_n falling edge, registered so the
  // FSM sees a clean single-cycle pulse.
  assign frame_edge_d = vs_prev_q & ~vs_sync2_q;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    fcnt_inc = fcnt_q + FCNT_W'(1);
    unique case (state_q)
      IDLE: begin
        // A frame edge coinciding with the request is too early: the
        // request waits for the following frame.
        if (req) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (frame_edge_q) begin
          state_d = ACTIVE;
          fcnt_d  = '0;
        end
      end
      ACTIVE: begin
        if (frame_edge_q) begin
          if (fcnt_inc == HOLD_LAST) begin
            fcnt_d  = '0;
            state_d = (COOLDOWN_FRAMES > 0) ? COOLDOWN : IDLE;
          end else begin
            fcnt_d = fcnt_inc;
          end
        end
      end
      COOLDOWN: begin
        // Requests arriving here are dropped, not queued.
        if (frame_edge_q) begin
          if (fcnt_inc == COOL_LAST) begin
            fcnt_d  = '0;
            state_d = IDLE;
          end else begin
            fcnt_d = fcnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
    // Outputs are decoded from the next state so they change together with
    // the state register rather than a cycle later.
    screen_reset_d = (state_d == ACTIVE);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_sync1_q     <= 1'b1;
      vs_sync2_q     <= 1'b1;
      vs_prev_q      <= 1'b1;
      frame_edge_q   <= 1'b0;
      state_q        <= IDLE;
      fcnt_q         <= '0;
      screen_reset_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      vs_sync1_q     <= vsync_n;
      vs_sync2_q     <= vs_sync1_q;
      vs_prev_q      <= vs_sync2_q;
      frame_edge_q   <= frame_edge_d;
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      screen_reset_q <= screen_reset_d;
      busy_q         <= busy_d;
    end
  end

  assign screen_reset = screen_reset_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_screen_reset_request.sv
// Bench for screen_reset_request: two instances (cooldown 3 and cooldown 0)
// share clock, reset and vsync. Stimulus pushes expected output transitions
// ({screen_reset, busy} and the cycle they appear) into per-instance queues;
// monitors pop and compare whenever an instance's outputs change.
module tb_screen_reset_request;

  typedef struct {
    int         cyc;
    logic [1:0] val;  // {screen_reset, busy}
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic key_n_b;
  logic round_over;
  logic round_over_b;
  logic vsync_n;
  logic sr_a, busy_a, sr_b, busy_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  bit   vs_en = 1'b0;
  int   vs_base = 0;
  ev_t  q_a[$];
  ev_t  q_b[$];
  logic [1:0] prev_a, prev_b, cur_a, cur_b;

  screen_reset_request #(
    .DEBOUNCE_CYCLES(4), .HOLD_FRAMES(2), .COOLDOWN_FRAMES(3)
  ) dut_a (
    .clk(clk), .reset(reset), .key_n(key_n), .round_over(round_over),
    .vsync_n(vsync_n), .screen_reset(sr_a), .busy(busy_a)
  );

  screen_reset_request #(
    .DEBOUNCE_CYCLES(4), .HOLD_FRAMES(2), .COOLDOWN_FRAMES(0)
  ) dut_b (
    .clk(clk), .reset(reset), .key_n(key_n_b), .round_over(round_over_b),
    .vsync_n(vsync_n), .screen_reset(sr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: one comparison per observed output transition.
  always @(negedge clk) begin
    ev_t e;
    cur_a = {sr_a, busy_a};
    if (mon_on && cur_a !== prev_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL dut_a unexpected: got %b at cycle %0d, required no change", cur_a, cyc);
      end else begin
        e = q_a.pop_front();
        if (e.cyc != cyc || e.val !== cur_a) begin
          errors++;
          $display("FAIL dut_a event: got %b at cycle %0d, required %b at cycle %0d",
                   cur_a, cyc, e.val, e.cyc);
        end
      end
    end
    prev_a = cur_a;
  end

  always @(negedge clk) begin
    ev_t e;
    cur_b = {sr_b, busy_b};
    if (mon_on && cur_b !== prev_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL dut_b unexpected: got %b at cycle %0d, required no change", cur_b, cyc);
      end else begin
        e = q_b.pop_front();
        if (e.cyc != cyc || e.val !== cur_b) begin
          errors++;
          $display("FAIL dut_b event: got %b at cycle %0d, required %b at cycle %0d",
                   cur_b, cyc, e.val, e.cyc);
        end
      end
    end
    prev_b = cur_b;
  end

  function automatic int e(input int k);
    return vs_base + 3 + 100 * k;  // cycle the FSM sees the k-th frame edge
  endfunction

  task automatic push_a(input int c, input logic [1:0] v);
    ev_t x;
    x.cyc = c; x.val = v;
    q_a.push_back(x);
  endtask

  task automatic push_b(input int c, input logic [1:0] v);
    ev_t x;
    x.cyc = c; x.val = v;
    q_b.push_back(x);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle; inputs set after this call belong to the new cycle.
  task automatic step();
    @(negedge clk);
    round_over   = 1'b0;
    round_over_b = 1'b0;
    vsync_n = !(vs_en && cyc >= vs_base && ((cyc - vs_base) % 100) < 5);
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    int tf;
    int t0;
    reset = 1'b1; key_n = 1'b1; key_n_b = 1'b1;
    round_over = 1'b0; round_over_b = 1'b0; vsync_n = 1'b1;

    repeat (3) step();
    check("reset_sr_a", sr_a, 1'b0);
    check("reset_busy_a", busy_a, 1'b0);
    check("reset_sr_b", sr_b, 1'b0);
    check("reset_busy_b", busy_b, 1'b0);
    reset = 1'b0;
    step();
    mon_on = 1'b1;
    step();

    // Bounce: 2-cycle segments never satisfy the 4-cycle debounce.
    for (int i = 0; i < 10; i++) begin
      key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
      step();
    end
    check("bounce_busy", busy_a, 1'b0);
    key_n = 1'b0;
    tf = cyc;
    push_a(tf + 8, 2'b01);  // press at tf+7, PENDING one cycle later
    repeat (10) step();
    key_n = 1'b1;
    repeat (10) step();
    check("press_busy", busy_a, 1'b1);
    check("press_pending_sr", sr_a, 1'b0);
    reset = 1'b1;
    push_a(cyc + 1, 2'b00);
    step();
    reset = 1'b0;
    step();

    // round_over, first vsync fall 40 cycles later.
    t0 = cyc;
    round_over = 1'b1;
    vs_base = t0 + 40;
    vs_en = 1'b1;
    push_a(t0 + 1, 2'b01);
    push_a(e(0) + 1, 2'b11);
    push_a(e(2) + 1, 2'b01);
    push_a(e(5) + 1, 2'b00);

    // Repeated requests during ACTIVE/COOLDOWN collapse into one assertion.
    goto(e(5) + 20);
    round_over = 1'b1;
    push_a(cyc + 1, 2'b01);
    push_a(e(6) + 1, 2'b11);
    push_a(e(8) + 1, 2'b01);
    push_a(e(11) + 1, 2'b00);
    for (int k = 1; k <= 11; k++) begin
      goto(e(5) + 20 + 50 * k);
      round_over = 1'b1;
    end
    goto(e(11) + 20);
    round_over = 1'b1;
    push_a(e(11) + 21, 2'b01);
    push_a(e(12) + 1, 2'b11);
    push_a(e(14) + 1, 2'b01);
    push_a(e(17) + 1, 2'b00);

    // Request coinciding with a frame edge waits for the next frame.
    goto(e(18));
    round_over = 1'b1;
    push_a(e(18) + 1, 2'b01);
    push_a(e(19) + 1, 2'b11);

    // Reset in the middle of ACTIVE discards the request.
    goto(e(20) + 10);
    reset = 1'b1;
    push_a(e(20) + 11, 2'b00);
    step();
    reset = 1'b0;
    goto(e(23) + 5);
    check("post_reset_sr", sr_a, 1'b0);
    check("post_reset_busy", busy_a, 1'b0);

    // Zero-cooldown instance: busy falls with screen_reset, next cycle accepted.
    goto(e(24) + 20);
    round_over_b = 1'b1;
    push_b(cyc + 1, 2'b01);
    push_b(e(25) + 1, 2'b11);
    push_b(e(27) + 1, 2'b00);
    goto(e(27) + 1);
    round_over_b = 1'b1;
    push_b(e(27) + 2, 2'b01);
    push_b(e(28) + 1, 2'b11);
    goto(e(28) + 10);

    while (q_a.size() > 0) begin
      ev_t x;
      x = q_a.pop_front();
      checks++; errors++;
      $display("FAIL dut_a missing: got no change, required %b at cycle %0d", x.val, x.cyc);
    end
    while (q_b.size() > 0) begin
      ev_t x;
      x = q_b.pop_front();
      checks++; errors++;
      $display("FAIL dut_b missing: got no change, required %b at cycle %0d", x.val, x.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
